// File: rtl/is_pkg.sv
// Shared issue/execute definitions: instruction field positions, writeback
// bundle layout and the register-read stage port counts.
package is_pkg;

  localparam int IS_INST_WIDTH = 66;
  localparam int DATA_WIDTH    = 16;
  localparam int PRG_NUM       = 64;
  localparam int PRG_IDX_BITS  = 6;
  localparam int BIT_INST_VLD  = 65;
  localparam int PSRC1_LSB     = 20;
  localparam int PSRC2_LSB     = 13;

  // Writeback bundle {vld, idx, data}, data in the LSBs
  localparam int WB_DATA_LSB   = 0;
  localparam int WB_IDX_LSB    = DATA_WIDTH;
  localparam int WB_VLD_BIT    = DATA_WIDTH + PRG_IDX_BITS;
  localparam int WB_WIDTH      = 1 + PRG_IDX_BITS + DATA_WIDTH;

  localparam int EX_WIDTH      = IS_INST_WIDTH + 2*DATA_WIDTH;

  localparam int FU_PORTS      = 4;
  localparam int WB_PORTS      = 4;
  localparam int RD_PORTS      = 2*FU_PORTS;

  typedef struct packed {
    logic                    vld;
    logic [PRG_IDX_BITS-1:0] idx;
    logic [DATA_WIDTH-1:0]   data;
  } wb_t;

endpackage

// File: rtl/prf.sv
// 64-entry physical register file: four writeback ports (higher port wins on
// an index collision) and eight combinational read ports with same-cycle
// writeback bypass. An invalid read source returns zero.
module prf
  import is_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [WB_PORTS*WB_WIDTH-1:0]     wb,
  input  logic [RD_PORTS-1:0]              rd_vld,
  input  logic [RD_PORTS*PRG_IDX_BITS-1:0] rd_idx,
  output logic [RD_PORTS*DATA_WIDTH-1:0]   rd_data
);

  wb_t                   wb_s [WB_PORTS];
  logic [DATA_WIDTH-1:0] mem  [PRG_NUM];
  logic [PRG_IDX_BITS-1:0] idx_r;
  logic [DATA_WIDTH-1:0]   data_r;

  // Unpack the flat writeback bus into per-port bundles
  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_s[p] = wb_t'(wb[p*WB_WIDTH +: WB_WIDTH]);
    end
  end

  // File update; later loop iterations override, so the higher port wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PRG_NUM; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_s[p].vld) begin
          mem[wb_s[p].idx] <= wb_s[p].data;
        end
      end
    end
  end

  // Read ports: zero if invalid, else file entry overridden by bypass
  always_comb begin
    rd_data = '0;
    idx_r   = '0;
    data_r  = '0;
    for (int r = 0; r < RD_PORTS; r++) begin
      idx_r  = rd_idx[r*PRG_IDX_BITS +: PRG_IDX_BITS];
      data_r = '0;
      if (rd_vld[r]) begin
        data_r = mem[idx_r];
        for (int p = 0; p < WB_PORTS; p++) begin
          if (wb_s[p].vld && (wb_s[p].idx == idx_r)) begin
            data_r = wb_s[p].data;
          end
        end
      end
      rd_data[r*DATA_WIDTH +: DATA_WIDTH] = data_r;
    end
  end

endmodule

// File: rtl/rf_stg.sv
// Register-read stage: reads both sources of each issued instruction from the
// physical register file and registers {inst, src1, src2} toward execute.
// Invalid instructions and ROB flushes produce all-zero bundles.
module rf_stg
  import is_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [IS_INST_WIDTH-1:0]     mul_ins_frm_is,
  input  logic [IS_INST_WIDTH-1:0]     alu1_ins_frm_is,
  input  logic [IS_INST_WIDTH-1:0]     alu2_ins_frm_is,
  input  logic [IS_INST_WIDTH-1:0]     adr_ins_frm_is,
  input  logic [WB_PORTS*WB_WIDTH-1:0] wb_frm_exe,
  input  logic [6:0]                   fls_frm_rob,
  output logic [EX_WIDTH-1:0]          mul_ins_to_exe,
  output logic [EX_WIDTH-1:0]          alu1_ins_to_exe,
  output logic [EX_WIDTH-1:0]          alu2_ins_to_exe,
  output logic [EX_WIDTH-1:0]          adr_ins_to_exe
);

  logic [IS_INST_WIDTH-1:0]         ins    [FU_PORTS];
  logic [EX_WIDTH-1:0]              ex_q   [FU_PORTS];
  logic [RD_PORTS-1:0]              rd_vld;
  logic [RD_PORTS*PRG_IDX_BITS-1:0] rd_idx;
  logic [RD_PORTS*DATA_WIDTH-1:0]   rd_data;
  logic                             flush;
  logic [5:0]                       unused_brn_idx;

  assign ins[0] = mul_ins_frm_is;
  assign ins[1] = alu1_ins_frm_is;
  assign ins[2] = alu2_ins_frm_is;
  assign ins[3] = adr_ins_frm_is;

  // The branch index only matters to the ROB; every flush squashes all ports
  assign flush          = fls_frm_rob[6];
  assign unused_brn_idx = fls_frm_rob[5:0];

  // Read port 2k serves src1 of FU port k, 2k+1 serves src2
  always_comb begin
    rd_vld = '0;
    rd_idx = '0;
    for (int k = 0; k < FU_PORTS; k++) begin
      rd_vld[2*k]   = ins[k][PSRC1_LSB+PRG_IDX_BITS];
      rd_vld[2*k+1] = ins[k][PSRC2_LSB+PRG_IDX_BITS];
      rd_idx[(2*k)*PRG_IDX_BITS   +: PRG_IDX_BITS] = ins[k][PSRC1_LSB +: PRG_IDX_BITS];
      rd_idx[(2*k+1)*PRG_IDX_BITS +: PRG_IDX_BITS] = ins[k][PSRC2_LSB +: PRG_IDX_BITS];
    end
  end

  prf u_prf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb      (wb_frm_exe),
    .rd_vld  (rd_vld),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // Output registers: squashed by flush, zeroed for invalid instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FU_PORTS; k++) begin
        ex_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < FU_PORTS; k++) begin
        if (flush || !ins[k][BIT_INST_VLD]) begin
          ex_q[k] <= '0;
        end else begin
          ex_q[k] <= {ins[k],
                      rd_data[(2*k)*DATA_WIDTH   +: DATA_WIDTH],
                      rd_data[(2*k+1)*DATA_WIDTH +: DATA_WIDTH]};
        end
      end
    end
  end

  assign mul_ins_to_exe  = ex_q[0];
  assign alu1_ins_to_exe = ex_q[1];
  assign alu2_ins_to_exe = ex_q[2];
  assign adr_ins_to_exe  = ex_q[3];

endmodule
